display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-shares one external BCD-to-7-segment decoder (active-low, {g,f,e,d,c,b,a}) across all clock display digits.
- On each refresh tick, snapshots the six time digits and edit/blink state, then feeds one digit per cycle to the decoder.
- Captures each decoded pattern into a shadow register and commits all HEX outputs at once, so the display never tears.
- Sits between the timekeeping/set-mode logic and the board HEX pins; also applies edit-field blinking and optional leading-zero blanking.

Parameters:
- DIGITS, 6: number of displayed digits; digit 0 = seconds ones, digit 5 = hours tens.
- BLANK_LEADING, 1: if 1, the top digit shows blank when its snapshot value is 0.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- tick  input  1  refresh request pulse, one cycle
- digits_in  input  4*DIGITS  packed BCD; digit k = [4k+3:4k]
- edit_field  input  2  0 none, 1 hours (digits 5,4), 2 minutes (3,2), 3 seconds (1,0)
- blink_phase  input  1  1 = blink-off half-period
- dec_bcd  output  4  BCD to the shared decoder
- dec_seg  input  7  decoder result, combinational from dec_bcd
- hex_out  output  7*DIGITS  committed segments; digit k = [7k+6:7k], active-low
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse: new hex_out valid
- overrun  output  1  sticky: a tick arrived while busy

Behaviour:
- Reset (synchronous, active-high; takes priority in any state, including mid-scan):
  - state IDLE; hex_out all 1s (blank); dec_bcd 4'hF.
  - busy, done and overrun 0; shadow contents discarded.
- States: IDLE -> SCAN(k = 0..DIGITS-1) -> COMMIT -> IDLE. All outputs are registered except dec_bcd, which is decoded from state and snapshot registers.
- IDLE:
  - dec_bcd 4'hF.
  - If tick=1 in cycle T: on that edge, snapshot digits_in, edit_field and blink_phase; go to SCAN k=0; busy becomes 1.
- SCAN k (cycle T+1+k):
  - dec_bcd = snapshot digit k.
  - At the edge, shadow[k] <= 7'h7F if digit k is masked, else dec_seg.
  - k increments; after k = DIGITS-1, go to COMMIT.
- Masking rules for digit k:
  - Blink mask: snapshot blink_phase=1 and k is inside the snapshot edit_field.
  - Leading blank: BLANK_LEADING=1, k = DIGITS-1, and snapshot digit = 0.
  - Out-of-range BCD (10..15) is not masked; the decoder's blank result is passed through unchanged.
- COMMIT (cycle T+DIGITS+1):
  - dec_bcd 4'hF.
  - At the edge, hex_out <= shadow; done <= 1; busy <= 0.
- Timing for DIGITS=6:
  - busy is high in cycles T+1..T+7.
  - hex_out updates and done is high in cycle T+8; done is low in all other cycles.
  - A tick in T+8 is accepted (IDLE).
- A tick sampled while busy=1 is dropped and sets overrun=1; overrun clears only on rst.
- Input changes after the snapshot do not affect the scan in progress.
- Edit fields that map beyond DIGITS-1 are ignored.

Test Plan:
- Reset, then digits_in=12:34:56 (digit5..0 = 1,2,3,4,5,6), edit_field=0, tick at T -> dec_bcd = 6,5,4,3,2,1 in T+1..T+6. In T+8: hex_out digit0=7'b0000010, digit5=7'b1111001, done=1 for one cycle; busy high in T+1..T+7.
- digits_in = 05:00:00, BLANK_LEADING=1, tick -> digit5=7'h7F, digit4=7'b0010010, digits 3..0=7'b1000000. Repeat with BLANK_LEADING=0 -> digit5=7'b1000000.
- edit_field=2, blink_phase=1, tick -> digits 3,2 = 7'h7F, all others decoded normally. Next tick with blink_phase=0 -> digits 3,2 show their decoded values.
- Tick at T, digits_in changed at T+2, second tick at T+4 -> hex_out reflects the T snapshot; overrun=1 and stays 1; no second done. A tick at T+8 starts a new scan with the new digits.
- rst asserted in T+3 of a scan -> next cycle hex_out all 1s, busy=0, no done pulse, overrun=0. A tick after reset completes normally.
- Digit value 4'hC in digit 1 -> dec_seg blank (7'h7F) is committed for digit 1; other digits are unaffected.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-shares one BCD-to-7-segment decoder across all clock digits
module display_scan_ctrl #(
    parameter int DIGITS        = 6,
    parameter bit BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [1:0]            edit_field,
    input  logic                  blink_phase,
    output logic [3:0]            dec_bcd,
    input  logic [6:0]            dec_seg,
    output logic [7*DIGITS-1:0]   hex_out,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);
    localparam int KW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t              state, state_nxt;
    logic [KW-1:0]       k, k_nxt;
    logic [4*DIGITS-1:0] snap_digits;
    logic [1:0]          snap_field;
    logic                snap_blink;
    logic [7*DIGITS-1:0] shadow;
    logic [3:0]          cur;
    logic                blink_hit;
    logic                lead_hit;

    // current digit under scan and whether it must be forced blank
    always_comb begin
        cur       = snap_digits[4*k +: 4];
        blink_hit = snap_blink && snap_field != 2'd0 && (int'(k) >> 1) == 3 - int'(snap_field);
        lead_hit  = BLANK_LEADING && int'(k) == DIGITS - 1 && cur == 4'd0;
    end

    // next-state and decoder drive; decoder sees 4'hF whenever not scanning
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        dec_bcd   = 4'hF;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = SCAN;
                    k_nxt     = '0;
                end
            end
            SCAN: begin
                dec_bcd = cur;
                k_nxt   = k + 1'b1;
                if (int'(k) == DIGITS - 1) state_nxt = COMMIT;
            end
            COMMIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // snapshot, shadow capture and atomic commit of all digits
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_digits <= '0;
            snap_field  <= '0;
            snap_blink  <= 1'b0;
            shadow      <= '1;
            hex_out     <= '1;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done <= (state == COMMIT);
            if (state == IDLE && tick) begin
                snap_digits <= digits_in;
                snap_field  <= edit_field;
                snap_blink  <= blink_phase;
                busy        <= 1'b1;
            end
            if (state != IDLE && tick) overrun <= 1'b1;
            if (state == SCAN) shadow[7*k +: 7] <= (blink_hit || lead_hit) ? 7'h7F : dec_seg;
            if (state == COMMIT) begin
                hex_out <= shadow;
                busy    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: model-checked bench for the shared-decoder display scanner
module tb_display_scan_ctrl;
    localparam int DIGITS = 6;
    localparam logic [41:0] ALL1 = '1;

    logic        clk, rst, tick, blink_phase;
    logic [23:0] digits_in;
    logic [1:0]  edit_field;
    logic [3:0]  a_bcd, b_bcd;
    logic [6:0]  a_seg, b_seg;
    logic [41:0] a_hex, b_hex;
    logic        a_busy, a_done, a_ovr, b_busy, b_done, b_ovr;

    int checks = 0;
    int errors = 0;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    assign a_seg = seg7(a_bcd);
    assign b_seg = seg7(b_bcd);

    display_scan_ctrl #(.DIGITS(6), .BLANK_LEADING(1)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .digits_in(digits_in), .edit_field(edit_field),
        .blink_phase(blink_phase), .dec_bcd(a_bcd), .dec_seg(a_seg), .hex_out(a_hex),
        .busy(a_busy), .done(a_done), .overrun(a_ovr));

    display_scan_ctrl #(.DIGITS(6), .BLANK_LEADING(0)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .digits_in(digits_in), .edit_field(edit_field),
        .blink_phase(blink_phase), .dec_bcd(b_bcd), .dec_seg(b_seg), .hex_out(b_hex),
        .busy(b_busy), .done(b_done), .overrun(b_ovr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // whole display picture as the rules describe it, computed at snapshot time
    function automatic logic [41:0] expect_hex(input logic [23:0] dig, input logic [1:0] field,
                                               input logic blink, input logic blank_lead);
        logic [41:0] r;
        for (int j = 0; j < DIGITS; j++) begin
            logic [3:0] d;
            logic in_field, lead;
            d = dig[4*j +: 4];
            in_field = (field == 2'd1 && j >= 4) || (field == 2'd2 && (j == 2 || j == 3)) ||
                       (field == 2'd3 && j <= 1);
            lead = blank_lead && j == DIGITS - 1 && d == 4'd0;
            r[7*j +: 7] = ((blink && in_field) || lead) ? 7'h7F : seg7(d);
        end
        return r;
    endfunction

    int          n;
    logic        model_ok = 1'b0;
    logic        m_done, m_ovr;
    logic [23:0] m_dig;
    logic [41:0] m_hex_a, m_hex_b, m_pend_a, m_pend_b;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            model_ok <= 1'b1;
            n        <= -1;
            m_hex_a  <= ALL1;
            m_hex_b  <= ALL1;
            m_ovr    <= 1'b0;
        end else if (n < 0) begin
            if (tick) begin
                m_dig    <= digits_in;
                m_pend_a <= expect_hex(digits_in, edit_field, blink_phase, 1'b1);
                m_pend_b <= expect_hex(digits_in, edit_field, blink_phase, 1'b0);
                n        <= 1;
            end
        end else begin
            if (tick) m_ovr <= 1'b1;
            if (n == DIGITS + 1) begin
                m_hex_a <= m_pend_a;
                m_hex_b <= m_pend_b;
                m_done  <= 1'b1;
                n       <= -1;
            end else begin
                n <= n + 1;
            end
        end
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        logic [3:0] eb;
        @(negedge clk);
        if (model_ok) begin
            eb = (n >= 1 && n <= DIGITS) ? m_dig[4*(n-1) +: 4] : 4'hF;
            cmp("a_hex", a_hex, m_hex_a);
            cmp("b_hex", b_hex, m_hex_b);
            cmp("a_done", a_done, m_done);
            cmp("b_done", b_done, m_done);
            cmp("a_busy", a_busy, n >= 0);
            cmp("b_busy", b_busy, n >= 0);
            cmp("a_ovr", a_ovr, m_ovr);
            cmp("b_ovr", b_ovr, m_ovr);
            cmp("a_bcd", a_bcd, eb);
            cmp("b_bcd", b_bcd, eb);
        end
    endtask

    task automatic scan_start();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic run_scan();
        scan_start();
        for (int i = 0; i < 7; i++) cyc();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; digits_in = '0; edit_field = 2'd0; blink_phase = 1'b0;
        cyc(); cyc();
        cmp("rst_hex", a_hex, ALL1);
        cmp("rst_bcd", a_bcd, 4'hF);
        cmp("rst_busy", a_busy, 1'b0);
        rst = 1'b0;
        cyc();
        // 12:34:56, scan order and commit timing
        digits_in = 24'h123456;
        scan_start();
        for (int i = 0; i < 6; i++) begin
            cmp("s1_bcd", a_bcd, 64'(6 - i));
            cmp("s1_busy", a_busy, 1'b1);
            cyc();
        end
        cmp("s1_busy7", a_busy, 1'b1);
        cmp("s1_done7", a_done, 1'b0);
        cyc();
        cmp("s1_done", a_done, 1'b1);
        cmp("s1_busy8", a_busy, 1'b0);
        cmp("s1_dig0", a_hex[6:0], 7'b0000010);
        cmp("s1_dig5", a_hex[41:35], 7'b1111001);
        cyc();
        cmp("s1_done9", a_done, 1'b0);
        // 05:00:00 leading-zero blanking on and off
        digits_in = 24'h050000;
        run_scan();
        cmp("s2_a_dig5", a_hex[41:35], 7'h7F);
        cmp("s2_b_dig5", b_hex[41:35], 7'b1000000);
        cmp("s2_dig4", a_hex[34:28], 7'b0010010);
        cmp("s2_low", a_hex[27:0], {4{7'b1000000}});
        cyc();
        // minutes field blinking
        digits_in = 24'h123456; edit_field = 2'd2; blink_phase = 1'b1;
        run_scan();
        cmp("s3_blank", a_hex[27:14], 14'h3FFF);
        cmp("s3_dig1", a_hex[13:7], 7'b0010010);
        cmp("s3_dig4", a_hex[34:28], 7'b0100100);
        blink_phase = 1'b0;
        cyc();
        run_scan();
        cmp("s3_dig2", a_hex[20:14], 7'b0011001);
        cmp("s3_dig3", a_hex[27:21], 7'b0110000);
        edit_field = 2'd0;
        cyc();
        // input change mid-scan and a dropped tick
        digits_in = 24'h111111;
        scan_start();
        cyc();
        digits_in = 24'h222222;
        cyc(); cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cmp("s4_ovr", a_ovr, 1'b1);
        cyc(); cyc(); cyc();
        cmp("s4_done", a_done, 1'b1);
        cmp("s4_hex", a_hex, {6{7'b1111001}});
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cmp("s4_nodone", a_done, 1'b0);
        for (int i = 0; i < 7; i++) cyc();
        cmp("s4_done2", a_done, 1'b1);
        cmp("s4_hex2", a_hex, {6{7'b0100100}});
        cmp("s4_ovr2", a_ovr, 1'b1);
        cyc();
        // reset mid-scan
        digits_in = 24'h987654;
        scan_start();
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cmp("s5_hex", a_hex, ALL1);
        cmp("s5_busy", a_busy, 1'b0);
        cmp("s5_done", a_done, 1'b0);
        cmp("s5_ovr", a_ovr, 1'b0);
        for (int i = 0; i < 8; i++) cyc();
        // out-of-range digit passes decoder blank through
        digits_in = 24'h1234C6;
        run_scan();
        cmp("s6_done", a_done, 1'b1);
        cmp("s6_dig1", a_hex[13:7], 7'h7F);
        cmp("s6_dig0", a_hex[6:0], 7'b0000010);
        cmp("s6_dig2", a_hex[20:14], 7'b0011001);
        cmp("s6_ovr", a_ovr, 1'b0);
        for (int i = 0; i < 4; i++) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
